// File: rtl/alu_sequencer_if.sv
// Purpose : bundles the program-ROM fetch port and the ALU drive/result port of alu_sequencer.
// Latency : none (wires only); ROM data is expected one cycle after instr_addr, ALU result combinationally.
// Backpressure: none; both ROM and ALU are fixed-latency slaves with no stall path.
// Ports   : master = sequencer (drives instr_addr and ALU controls/operands, receives instr_data/alu_result);
//           slave  = ROM + ALU side (receives address/controls, returns instr_data/alu_result).
interface alu_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] instr_addr;
   logic [7:0]        instr_data;
   logic              alu_add_sub;
   logic              alu_set_low;
   logic              alu_set_high;
   logic [7:0]        alu_operanda;
   logic [7:0]        alu_operandb;
   logic [7:0]        alu_result;

   modport master (
      output instr_addr,
      input  instr_data,
      output alu_add_sub,
      output alu_set_low,
      output alu_set_high,
      output alu_operanda,
      output alu_operandb,
      input  alu_result
   );

   modport slave (
      input  instr_addr,
      output instr_data,
      input  alu_add_sub,
      input  alu_set_low,
      input  alu_set_high,
      input  alu_operanda,
      input  alu_operandb,
      output alu_result
   );
endinterface

// File: rtl/alu_sequencer.sv
// Purpose : micro-sequencer fetching 8-bit instructions from a sync ROM, driving the 8-bit ALU, writing back to 4x8 regs.
// Latency : 3 cycles per instruction (FETCH/DECODE/EXEC); a run is 3*PROG_LEN busy cycles plus one DONE cycle.
// Backpressure: none; i_start is only honoured in IDLE and ignored while busy or in DONE.
// Ports   : i_clk, i_reset (sync, active high), i_start; bus (ROM fetch + ALU drive, master side);
//           o_reg_out = R3 (motor pattern), o_busy (FETCH..EXEC), o_done (one-cycle pulse in DONE).
module alu_sequencer #(
   parameter int ADDR_W   = 4,
   parameter int PROG_LEN = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   alu_sequencer_if.master bus,
   output logic [7:0]      o_reg_out,
   output logic            o_busy,
   output logic            o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_ir;
   logic [7:0]        r_regs [4];

   // Instruction fields; rs and imm4 share the low bits of the instruction.
   logic [1:0] w_op;
   logic [1:0] w_rd;
   logic [1:0] w_rs;
   logic [3:0] w_imm;

   logic       w_add_sub;
   logic       w_set_low;
   logic       w_set_high;
   logic [7:0] w_opa;
   logic [7:0] w_opb;
   logic       w_last;

   assign w_op   = r_ir[7:6];
   assign w_rd   = r_ir[5:4];
   assign w_rs   = r_ir[3:2];
   assign w_imm  = r_ir[3:0];
   assign w_last = (r_pc == LAST_PC);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and ALU drive. The ALU sees a quiet bus (all zero) outside EXEC.
   always_comb begin
      w_state_nxt = r_state;
      w_add_sub   = 1'b0;
      w_set_low   = 1'b0;
      w_set_high  = 1'b0;
      w_opa       = 8'h00;
      w_opb       = 8'h00;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_opa = r_regs[w_rd];
            case (w_op)
               2'b00: begin
                  w_opb = r_regs[w_rs];
               end
               2'b01: begin
                  w_add_sub = 1'b1;
                  w_opb     = r_regs[w_rs];
               end
               2'b10: begin
                  w_set_low = 1'b1;
                  w_opb     = {4'h0, w_imm};
               end
               default: begin
                  w_set_high = 1'b1;
                  w_opb      = {4'h0, w_imm};
               end
            endcase
            w_state_nxt = w_last ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: pc, instruction register and register file. Reset overrides any
   // writeback on the same edge, so an aborted EXEC leaves no trace.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc <= '0;
         r_ir <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= 8'h00;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_pc <= '0;
               end
            end
            S_DECODE: begin
               r_ir <= bus.instr_data;
            end
            S_EXEC: begin
               // Operands were read combinationally from the pre-write regs,
               // so rd == rs uses the old value.
               r_regs[w_rd] <= bus.alu_result;
               if (!w_last) begin
                  r_pc <= r_pc + 1'b1;
               end
            end
            S_DONE: begin
               // pc only wraps back to 0 on the way out of a run.
               r_pc <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.instr_addr   = r_pc;
   assign bus.alu_add_sub  = w_add_sub;
   assign bus.alu_set_low  = w_set_low;
   assign bus.alu_set_high = w_set_high;
   assign bus.alu_operanda = w_opa;
   assign bus.alu_operandb = w_opb;

   assign o_reg_out = r_regs[3];
   assign o_busy    = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
   assign o_done    = (r_state == S_DONE);

endmodule
